div_hilo_unit: RTL and testbench

- Front-end and writeback stage for the sequential `Division` core.
- Accepts a divide request from the CPU execute stage and drives `start`/`a`/`b` of the divider.
- Waits out the divider's fixed latency, then captures `q`/`r` into architectural LO/HI registers.
- Exposes `busy` so the pipeline stalls on dependent reads. Also handles divide-by-zero and direct HI/LO writes.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_sign_fix.sv | 52 +++++
 rtl/div_hilo_unit.sv | 176 +++++++++++++++++
 tb/tb_div_hilo_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the HI/LO divide front-end: FSM encoding,
// capture-path selector, default sizing and the special result constants.
package div_pkg;

   localparam int DIV_WIDTH_DEF   = 32;
   localparam int DIV_LATENCY_DEF = 34;
   localparam int CNT_W           = 8;

   localparam logic [DIV_WIDTH_DEF-1:0] DBZ_QUOTIENT = '1;
   localparam logic [DIV_WIDTH_DEF-1:0] INT_MIN      = {1'b1, {(DIV_WIDTH_DEF-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_CAPTURE = 2'd2
   } div_state_t;

   typedef enum logic [1:0] {
      CAP_DIV = 2'd0,
      CAP_DBZ = 2'd1,
      CAP_OVF = 2'd2
   } cap_kind_t;

endpackage

// File: rtl/div_sign_fix.sv
// Combinational sign handling around the unsigned divider: operand magnitudes
// on the request side, quotient/remainder re-signing on the result side.
module div_sign_fix
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_signed,
   output logic [WIDTH-1:0] mag_a,
   output logic [WIDTH-1:0] mag_b,
   output logic             req_neg_q,
   output logic             req_neg_r,
   output logic             req_ovf,
   input  logic [WIDTH-1:0] div_q,
   input  logic [WIDTH-1:0] div_r,
   input  logic             neg_q,
   input  logic             neg_r,
   output logic [WIDTH-1:0] res_q,
   output logic [WIDTH-1:0] res_r
);

   localparam logic [WIDTH-1:0] INT_MIN_W = {INT_MIN[DIV_WIDTH_DEF-1], {(WIDTH-1){1'b0}}};

   function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] v);
      logic signed [WIDTH-1:0] sv;
      sv = v;
      return neg ? -sv : sv;
   endfunction

   logic signed [WIDTH-1:0] sa;
   logic signed [WIDTH-1:0] sb;
   logic                    a_neg;
   logic                    b_neg;

   assign sa    = req_a;
   assign sb    = req_b;
   assign a_neg = req_signed && (sa < 0);
   assign b_neg = req_signed && (sb < 0);

   // INT_MIN maps onto itself, which is its correct unsigned magnitude.
   assign mag_a     = neg_if(a_neg, req_a);
   assign mag_b     = neg_if(b_neg, req_b);
   assign req_neg_q = a_neg ^ b_neg;
   assign req_neg_r = a_neg;
   assign req_ovf   = req_signed && (req_a == INT_MIN_W) && (req_b == '1);

   assign res_q = neg_if(neg_q, div_q);
   assign res_r = neg_if(neg_r, div_r);

endmodule

// File: rtl/div_hilo_unit.sv
// Request/writeback front-end for the fixed-latency sequential divider with
// architectural HI/LO registers. Define SIGNED_DIV_EN to honour req_signed.
module div_hilo_unit
   import div_pkg::*;
#(
   parameter int WIDTH       = DIV_WIDTH_DEF,
   parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic             req_signed,
   output logic             div_start,
   output logic [WIDTH-1:0] div_a,
   output logic [WIDTH-1:0] div_b,
   input  logic [WIDTH-1:0] div_q,
   input  logic [WIDTH-1:0] div_r,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             dbz
);

   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(DIV_LATENCY - 1);
   localparam logic [WIDTH-1:0] DBZ_Q     = {WIDTH{DBZ_QUOTIENT[0]}};
   localparam logic [WIDTH-1:0] INT_MIN_W = {INT_MIN[DIV_WIDTH_DEF-1], {(WIDTH-1){1'b0}}};

   div_state_t       state;
   cap_kind_t        cap_kind;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] op_a;
   logic             accept;
   logic             req_dbz;

   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_r;
   logic             req_ovf;

   assign accept  = (state == ST_IDLE) && req_valid;
   assign req_dbz = (req_b == '0);

`ifdef SIGNED_DIV_EN
   logic req_neg_q;
   logic req_neg_r;
   logic neg_q;
   logic neg_r;

   div_sign_fix #(
      .WIDTH (WIDTH)
   ) u_sign_fix (
      .req_a      (req_a),
      .req_b      (req_b),
      .req_signed (req_signed),
      .mag_a      (mag_a),
      .mag_b      (mag_b),
      .req_neg_q  (req_neg_q),
      .req_neg_r  (req_neg_r),
      .req_ovf    (req_ovf),
      .div_q      (div_q),
      .div_r      (div_r),
      .neg_q      (neg_q),
      .neg_r      (neg_r),
      .res_q      (res_q),
      .res_r      (res_r)
   );

   always_ff @(posedge clock) begin
      if (accept) begin
         neg_q <= req_neg_q;
         neg_r <= req_neg_r;
      end
   end
`else
   logic unused_signed;

   assign unused_signed = req_signed;
   assign mag_a         = req_a;
   assign mag_b         = req_b;
   assign req_ovf       = 1'b0;
   assign res_q         = div_q;
   assign res_r         = div_r;
`endif

   // Dividend kept for the divide-by-zero writeback into HI.
   always_ff @(posedge clock) begin
      if (accept) begin
         op_a <= req_a;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cap_kind  <= CAP_DIV;
         cnt       <= '0;
         hi        <= '0;
         lo        <= '0;
         dbz       <= 1'b0;
         busy      <= 1'b0;
         req_ready <= 1'b1;
         div_start <= 1'b0;
         div_a     <= '0;
         div_b     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (hi_we) hi <= wdata;
               if (lo_we) lo <= wdata;
               if (req_valid) begin
                  dbz       <= 1'b0;
                  div_a     <= mag_a;
                  div_b     <= mag_b;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
                  // Zero divisor and INT_MIN/-1 never reach the divider.
                  if (req_dbz) begin
                     cap_kind <= CAP_DBZ;
                     state    <= ST_CAPTURE;
                  end else if (req_ovf) begin
                     cap_kind <= CAP_OVF;
                     state    <= ST_CAPTURE;
                  end else begin
                     cap_kind  <= CAP_DIV;
                     state     <= ST_RUN;
                     div_start <= 1'b1;
                     cnt       <= CNT_LOAD;
                  end
               end
            end
            ST_RUN: begin
               if (cnt == '0) begin
                  state     <= ST_CAPTURE;
                  div_start <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_CAPTURE: begin
               case (cap_kind)
                  CAP_DBZ: begin
                     lo  <= DBZ_Q;
                     hi  <= op_a;
                     dbz <= 1'b1;
                  end
                  CAP_OVF: begin
                     lo <= INT_MIN_W;
                     hi <= '0;
                  end
                  default: begin
                     lo <= res_q;
                     hi <= res_r;
                  end
               endcase
               state     <= ST_IDLE;
               busy      <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               busy      <= 1'b0;
               req_ready <= 1'b1;
               div_start <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_hilo_unit.sv
// Randomized and directed bench for div_hilo_unit against an arithmetic
// reference model and a behavioural fixed-latency divider.
module tb_div_hilo_unit;

   localparam int W = 32;
   localparam int L = 34;

   logic          clock = 1'b0;
   logic          reset_n = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [W-1:0]  req_a = '0;
   logic [W-1:0]  req_b = '0;
   logic          req_signed = 1'b0;
   logic          div_start;
   logic [W-1:0]  div_a;
   logic [W-1:0]  div_b;
   logic [W-1:0]  div_q;
   logic [W-1:0]  div_r;
   logic          hi_we = 1'b0;
   logic          lo_we = 1'b0;
   logic [W-1:0]  wdata = '0;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;
   logic          busy;
   logic          dbz;

   int n_checks = 0;
   int n_errors = 0;

   div_hilo_unit #(.WIDTH(W), .DIV_LATENCY(L)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_signed (req_signed),
      .div_start  (div_start),
      .div_a      (div_a),
      .div_b      (div_b),
      .div_q      (div_q),
      .div_r      (div_r),
      .hi_we      (hi_we),
      .lo_we      (lo_we),
      .wdata      (wdata),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy),
      .dbz        (dbz)
   );

   always #5 clock = ~clock;

   // Behavioural divider: results are garbage until start has been high L cycles.
   int dcyc;
   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) dcyc <= 0;
      else          dcyc <= div_start ? dcyc + 1 : 0;
   end
   always_comb begin
      div_q = 32'hBAD0_0000 | W'(dcyc);
      div_r = 32'h0BAD_0000 | W'(dcyc);
      if (dcyc >= L && div_b != '0) begin
         div_q = div_a / div_b;
         div_r = div_a % div_b;
      end
   end

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                   output logic [W-1:0] q, output logic [W-1:0] r,
                                   output logic z, output bit bypass, output logic [W-1:0] ma,
                                   output logic [W-1:0] mb);
      logic eff;
      int   sa, sb;
`ifdef SIGNED_DIV_EN
      eff = sgn;
`else
      eff = 1'b0;
`endif
      sa = int'(a);
      sb = int'(b);
      z = 1'b0;
      bypass = 1'b0;
      ma = (eff && sa < 0) ? W'(-sa) : a;
      mb = (eff && sb < 0) ? W'(-sb) : b;
      if (b == 0) begin
         q = '1; r = a; z = 1'b1; bypass = 1'b1;
      end else if (eff && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000; r = '0; bypass = 1'b1;
      end else if (eff) begin
         q = W'(sa / sb); r = W'(sa % sb);
      end else begin
         q = a / b; r = a % b;
      end
   endfunction

   task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sgn, input bit poke_busy, input bit wr_with_req);
      logic [W-1:0] eq, er, ema, emb;
      logic         ez;
      bit           byp;
      int           lat, starts;
      ref_div(a, b, sgn, eq, er, ez, byp, ema, emb);
      @(negedge clock);
      check({tag, "_ready"}, W'(req_ready), 1);
      req_valid = 1'b1; req_a = a; req_b = b; req_signed = sgn;
      if (wr_with_req) begin hi_we = 1'b1; wdata = 32'h1234_5678; end
      @(negedge clock);
      req_valid = 1'b0; hi_we = 1'b0;
      check({tag, "_busy"}, W'(busy), 1);
      if (!byp) begin
         check({tag, "_dbzclr"}, W'(dbz), 0);
         check({tag, "_diva"}, div_a, ema);
         check({tag, "_divb"}, div_b, emb);
         if (wr_with_req) check({tag, "_wr"}, hi, 32'h1234_5678);
      end
      lat = 0; starts = 0;
      while (busy && lat < 400) begin
         if (div_start) starts++;
         if (poke_busy && lat == 3) begin
            hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD;
         end else begin
            hi_we = 1'b0; lo_we = 1'b0;
         end
         @(negedge clock);
         lat++;
      end
      hi_we = 1'b0; lo_we = 1'b0;
      check({tag, "_lat"}, W'(lat), byp ? 1 : L + 1);
      check({tag, "_starts"}, W'(starts), byp ? 0 : L);
      check({tag, "_lo"}, lo, eq);
      check({tag, "_hi"}, hi, er);
      check({tag, "_dbz"}, W'(dbz), W'(ez));
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      int lat;
      bit bad_ready;

      #1 reset_n = 1'b0;
      #1;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_busy", W'(busy), 0);
      check("rst_dbz", W'(dbz), 0);
      check("rst_start", W'(div_start), 0);
      check("rst_diva", div_a, 0);
      check("rst_divb", div_b, 0);
      check("rst_ready", W'(req_ready), 1);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;

      run_div("u7_3", 7, 3, 1'b0, 1'b0, 1'b0);
      run_div("dbz5", 5, 0, 1'b0, 1'b0, 1'b0);
      run_div("poke9_4", 9, 4, 1'b0, 1'b1, 1'b0);
      run_div("u_big", 32'hFFFF_FFFF, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
      run_div("wr_req", 50, 8, 1'b0, 1'b0, 1'b1);
      run_div("dbz_big", 32'h8000_0001, 0, 1'b0, 1'b0, 1'b0);

      // Direct writes in IDLE
      @(negedge clock);
      hi_we = 1'b1; wdata = 32'hDEAD;
      @(negedge clock);
      hi_we = 1'b0;
      check("mthi_hi", hi, 32'hDEAD);
      check("mthi_lo", lo, '1);
      lo_we = 1'b1; wdata = 32'h0000_BEEF;
      @(negedge clock);
      lo_we = 1'b0;
      check("mtlo_lo", lo, 32'h0000_BEEF);
      check("mtlo_hi", hi, 32'hDEAD);
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
      @(negedge clock);
      hi_we = 1'b0; lo_we = 1'b0;
      check("mtboth_hi", hi, 32'hCAFE_F00D);
      check("mtboth_lo", lo, 32'hCAFE_F00D);

      // Reset in the middle of RUN aborts asynchronously
      @(negedge clock);
      req_valid = 1'b1; req_a = 100; req_b = 7; req_signed = 1'b0;
      @(negedge clock);
      req_valid = 1'b0;
      repeat (10) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      check("mid_rst_hi", hi, 0);
      check("mid_rst_lo", lo, 0);
      check("mid_rst_busy", W'(busy), 0);
      check("mid_rst_start", W'(div_start), 0);
      @(negedge clock);
      reset_n = 1'b1;
      run_div("redo100_7", 100, 7, 1'b0, 1'b0, 1'b0);

      // Back-to-back with req_valid held high
      @(negedge clock);
      req_valid = 1'b1; req_a = 20; req_b = 6; req_signed = 1'b0;
      @(negedge clock);
      req_a = 15; req_b = 4;
      lat = 0; bad_ready = 1'b0;
      while (busy && lat < 400) begin
         if (req_ready) bad_ready = 1'b1;
         @(negedge clock);
         lat++;
      end
      check("b2b_ready_busy", W'(bad_ready), 0);
      check("b2b_lat1", W'(lat), L + 1);
      check("b2b_lo1", lo, 3);
      check("b2b_hi1", hi, 2);
      check("b2b_idle_ready", W'(req_ready), 1);
      @(negedge clock);
      req_valid = 1'b0;
      check("b2b_busy2", W'(busy), 1);
      lat = 0;
      while (busy && lat < 400) begin
         @(negedge clock);
         lat++;
      end
      check("b2b_lat2", W'(lat), L + 1);
      check("b2b_lo2", lo, 3);
      check("b2b_hi2", hi, 3);

`ifdef SIGNED_DIV_EN
      run_div("s_m7_2", -32'sd7, 2, 1'b1, 1'b0, 1'b0);
      run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      run_div("s_dbz", -32'sd9, 0, 1'b1, 1'b0, 1'b0);
      run_div("s_7_m2", 7, -32'sd2, 1'b1, 1'b0, 1'b0);
`endif

      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = '0;
            1:       rb = W'($urandom_range(1, 15));
            2:       rb = $urandom & 32'h0000_FFFF;
            default: rb = $urandom;
         endcase
         run_div($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
